// File: rtl/z80_bus_arbiter.sv
// Shares the tv80s memory/IO bus between the CPU and one DMA master over the BUSRQ/BUSAK handshake.
// Define ARB_WATCHDOG_EN to build the MAX_HOLD hold watchdog and its forced release.
module z80_bus_arbiter #(
    parameter int MIN_GAP  = 16,
    parameter int MAX_HOLD = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic        dma_req,
    output logic        dma_gnt,
    output logic        mem_sel,
    output logic        dma_abort,
    output logic        busy,
    output logic [15:0] grant_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GRANT   = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    localparam logic [7:0] LP_MIN_GAP = 8'(MIN_GAP);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_busrq_n;
    logic        w_busrq_n_next;
    logic        r_dma_gnt;
    logic        w_dma_gnt_next;
    logic        r_mem_sel;
    logic        w_mem_sel_next;
    logic        r_busy;
    logic        w_busy_next;
    logic [15:0] r_grant_cnt;
    logic [15:0] w_grant_cnt_next;
    logic [7:0]  r_gap_cnt;
    logic [7:0]  w_gap_cnt_next;
    logic        w_req_ok;
    logic        w_grant_end;

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] LP_HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_cnt_next;
    logic        r_dma_abort;
    logic        w_dma_abort_next;
    // Set by a forced release; cleared once dma_req has been seen low in IDLE.
    logic        r_need_low;
    logic        w_need_low_next;

    assign w_req_ok = dma_req & ~r_need_low;
`else
    logic w_unused_max_hold;

    assign w_req_ok          = dma_req;
    assign w_unused_max_hold = (MAX_HOLD == 0);
`endif

    // NOTE: every output is a register loaded from its next-state value, so
    // the comb block decides both the transition and what the bus sees after it.
    always_comb begin
        w_state_next     = r_state;
        w_busrq_n_next   = r_busrq_n;
        w_dma_gnt_next   = r_dma_gnt;
        w_mem_sel_next   = r_mem_sel;
        w_grant_cnt_next = r_grant_cnt;
        w_gap_cnt_next   = r_gap_cnt;
        w_grant_end      = 1'b0;
`ifdef ARB_WATCHDOG_EN
        w_hold_cnt_next  = r_hold_cnt;
        w_dma_abort_next = 1'b0;
        w_need_low_next  = r_need_low;
`endif

        unique case (r_state)
            S_IDLE: begin
`ifdef ARB_WATCHDOG_EN
                if (!dma_req) begin
                    w_need_low_next = 1'b0;
                end
`endif
                if (w_req_ok) begin
                    w_state_next   = S_REQ;
                    w_busrq_n_next = 1'b0;
                end
            end

            S_REQ: begin
                if (!dma_req) begin
                    w_state_next   = S_RELEASE;
                    w_busrq_n_next = 1'b1;
                end else if (!busak_n) begin
                    w_state_next   = S_GRANT;
                    w_dma_gnt_next = 1'b1;
                    w_mem_sel_next = 1'b1;
`ifdef ARB_WATCHDOG_EN
                    w_hold_cnt_next = 16'd0;
`endif
                end
            end

            S_GRANT: begin
`ifdef ARB_WATCHDOG_EN
                w_hold_cnt_next = r_hold_cnt + 16'd1;
                if (!dma_req) begin
                    w_grant_end = 1'b1;
                end else if (r_hold_cnt == LP_HOLD_LAST) begin
                    w_grant_end      = 1'b1;
                    w_dma_abort_next = 1'b1;
                    w_need_low_next  = 1'b1;
                end
`else
                w_grant_end = ~dma_req;
`endif
                if (w_grant_end) begin
                    w_state_next     = S_RELEASE;
                    w_busrq_n_next   = 1'b1;
                    w_dma_gnt_next   = 1'b0;
                    w_mem_sel_next   = 1'b0;
                    w_grant_cnt_next = r_grant_cnt + 16'd1;
                end
            end

            S_RELEASE: begin
                w_busrq_n_next = 1'b1;
                // The CPU owns the bus again only once it drops its acknowledge.
                if (busak_n) begin
                    if (LP_MIN_GAP == 8'd0) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_GAP;
                        w_gap_cnt_next = LP_MIN_GAP;
                    end
                end
            end

            S_GAP: begin
                w_gap_cnt_next = r_gap_cnt - 8'd1;
                if (r_gap_cnt <= 8'd1) begin
                    w_state_next   = S_IDLE;
                    w_gap_cnt_next = 8'd0;
                end
            end

            default: begin
                w_state_next   = S_IDLE;
                w_busrq_n_next = 1'b1;
                w_dma_gnt_next = 1'b0;
                w_mem_sel_next = 1'b0;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busrq_n   <= 1'b1;
            r_dma_gnt   <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_busy      <= 1'b0;
            r_grant_cnt <= 16'd0;
            r_gap_cnt   <= 8'd0;
`ifdef ARB_WATCHDOG_EN
            r_hold_cnt  <= 16'd0;
            r_dma_abort <= 1'b0;
            r_need_low  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_busrq_n   <= w_busrq_n_next;
            r_dma_gnt   <= w_dma_gnt_next;
            r_mem_sel   <= w_mem_sel_next;
            r_busy      <= w_busy_next;
            r_grant_cnt <= w_grant_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
`ifdef ARB_WATCHDOG_EN
            r_hold_cnt  <= w_hold_cnt_next;
            r_dma_abort <= w_dma_abort_next;
            r_need_low  <= w_need_low_next;
`endif
        end
    end

    assign busrq_n   = r_busrq_n;
    assign dma_gnt   = r_dma_gnt;
    assign mem_sel   = r_mem_sel;
    assign busy      = r_busy;
    assign grant_cnt = r_grant_cnt;
`ifdef ARB_WATCHDOG_EN
    assign dma_abort = r_dma_abort;
`else
    assign dma_abort = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Self-checking bench for z80_bus_arbiter: the bench plays both the DMA master and the tv80s BUSAK side.
// Expected outputs come from a per-transaction timeline (phase lengths) derived from the arbiter rules.
module tb_z80_bus_arbiter;

    localparam int MIN_GAP  = 16;
    localparam int MAX_HOLD = 8;
`ifdef ARB_WATCHDOG_EN
    localparam int BASIC_HOLD = MAX_HOLD;
`else
    localparam int BASIC_HOLD = 20;
`endif

    // Output vector order: {busrq_n, dma_gnt, mem_sel, dma_abort, busy}
    localparam logic [4:0] O_IDLE  = 5'b10000;
    localparam logic [4:0] O_REQ   = 5'b00001;
    localparam logic [4:0] O_GRANT = 5'b01101;
    localparam logic [4:0] O_BACK  = 5'b10001;
    localparam logic [4:0] O_ABORT = 5'b10011;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        busak_n = 1'b1;
    logic        dma_req = 1'b0;
    logic        busrq_n;
    logic        dma_gnt;
    logic        mem_sel;
    logic        dma_abort;
    logic        busy;
    logic [15:0] grant_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    z80_bus_arbiter #(
        .MIN_GAP (MIN_GAP),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .busrq_n  (busrq_n),
        .busak_n  (busak_n),
        .dma_req  (dma_req),
        .dma_gnt  (dma_gnt),
        .mem_sel  (mem_sel),
        .dma_abort(dma_abort),
        .busy     (busy),
        .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] obs();
        return {busrq_n, dma_gnt, mem_sel, dma_abort, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From RELEASE: CPU keeps BUSAK low for rel_lat-1 more cycles, then GAP runs MIN_GAP cycles.
    task automatic finish_release(input string tag, input int rel_lat, input bit rereq);
        for (int i = 1; i < rel_lat; i++) begin
            busak_n = 1'b0;
            tick();
            n_total++;
            if (obs() !== O_BACK) begin
                n_bad++;
                $display("FAIL %s release_wait: got %b expected %b", tag, obs(), O_BACK);
            end
        end
        busak_n = 1'b1;
        tick();
        n_total++;
        if (obs() !== O_BACK) begin
            n_bad++;
            $display("FAIL %s gap_enter: got %b expected %b", tag, obs(), O_BACK);
        end
        if (rereq) dma_req = 1'b1;
        for (int i = 1; i < MIN_GAP; i++) begin
            busak_n = 1'($urandom_range(0, 1));
            tick();
            n_total++;
            if (obs() !== O_BACK) begin
                n_bad++;
                $display("FAIL %s gap_hold[%0d]: got %b expected %b", tag, i, obs(), O_BACK);
            end
        end
        busak_n = 1'b1;
        tick();
        n_total++;
        if (obs() !== O_IDLE) begin
            n_bad++;
            $display("FAIL %s gap_exit: got %b expected %b", tag, obs(), O_IDLE);
        end
        n_total++;
        if (grant_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s cnt_after_gap: got %h expected %h", tag, grant_cnt, exp_cnt);
        end
    endtask

    // One complete grant starting from IDLE (or the final GAP edge when dma_req is already high).
    task automatic run_txn(input string tag, input int ack_lat, input int hold_len,
                           input int rel_lat, input bit rereq);
        dma_req = 1'b1;
        busak_n = 1'b1;
        tick();
        n_total++;
        if (obs() !== O_REQ) begin
            n_bad++;
            $display("FAIL %s req_fall: got %b expected %b", tag, obs(), O_REQ);
        end
        for (int i = 1; i < ack_lat; i++) begin
            tick();
            n_total++;
            if (obs() !== O_REQ) begin
                n_bad++;
                $display("FAIL %s req_wait: got %b expected %b", tag, obs(), O_REQ);
            end
        end
        busak_n = 1'b0;
        tick();
        n_total++;
        if (obs() !== O_GRANT) begin
            n_bad++;
            $display("FAIL %s grant_rise: got %b expected %b", tag, obs(), O_GRANT);
        end
        for (int i = 1; i < hold_len; i++) begin
            tick();
            n_total++;
            if (obs() !== O_GRANT) begin
                n_bad++;
                $display("FAIL %s grant_hold[%0d]: got %b expected %b", tag, i, obs(), O_GRANT);
            end
        end
        dma_req = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (obs() !== O_BACK) begin
            n_bad++;
            $display("FAIL %s release: got %b expected %b", tag, obs(), O_BACK);
        end
        n_total++;
        if (grant_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s grant_cnt: got %h expected %h", tag, grant_cnt, exp_cnt);
        end
        finish_release(tag, rel_lat, rereq);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        dma_req = 1'b0;
        busak_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (obs() !== O_IDLE || grant_cnt !== 16'd0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b cnt %h expected %b cnt 0000", i, obs(), grant_cnt, O_IDLE);
            end
        end
        reset   = 1'b0;
        exp_cnt = 16'd0;
        tick();
        n_total++;
        if (obs() !== O_IDLE) begin
            n_bad++;
            $display("FAIL reset_exit: got %b expected %b", obs(), O_IDLE);
        end
    endtask

    task automatic test_spurious_ack();
        busak_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (obs() !== O_IDLE) begin
                n_bad++;
                $display("FAIL spurious_ack_idle[%0d]: got %b expected %b", i, obs(), O_IDLE);
            end
        end
        busak_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_txn("basic", 2, BASIC_HOLD, 3, 1'b0);
    endtask

    task automatic test_gap();
        run_txn("gap_first", 1, 5, 1, 1'b1);
        run_txn("gap_second", 3, 2, 2, 1'b0);
    endtask

    task automatic test_withdraw();
        for (int v = 0; v < 2; v++) begin
            int k;
            dma_req = 1'b1;
            busak_n = 1'b1;
            tick();
            n_total++;
            if (obs() !== O_REQ) begin
                n_bad++;
                $display("FAIL withdraw%0d req: got %b expected %b", v, obs(), O_REQ);
            end
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
                tick();
                n_total++;
                if (obs() !== O_REQ) begin
                    n_bad++;
                    $display("FAIL withdraw%0d req_wait: got %b expected %b", v, obs(), O_REQ);
                end
            end
            dma_req = 1'b0;
            busak_n = (v == 1) ? 1'b0 : 1'b1;
            tick();
            n_total++;
            if (obs() !== O_BACK || grant_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL withdraw%0d drop: got %b cnt %h expected %b cnt %h", v, obs(), grant_cnt, O_BACK, exp_cnt);
            end
            finish_release("withdraw", (v == 1) ? int'($urandom_range(2, 4)) : 1, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            bit rr;
            rr = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_txn("random", int'($urandom_range(1, 4)), int'($urandom_range(1, 8)),
                    int'($urandom_range(1, 4)), rr);
        end
    endtask

`ifdef ARB_WATCHDOG_EN
    task automatic test_watchdog();
        dma_req = 1'b1;
        busak_n = 1'b1;
        tick();
        n_total++;
        if (obs() !== O_REQ) begin
            n_bad++;
            $display("FAIL wd req: got %b expected %b", obs(), O_REQ);
        end
        busak_n = 1'b0;
        tick();
        n_total++;
        if (obs() !== O_GRANT) begin
            n_bad++;
            $display("FAIL wd grant_rise: got %b expected %b", obs(), O_GRANT);
        end
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            n_total++;
            if (obs() !== O_GRANT) begin
                n_bad++;
                $display("FAIL wd grant_hold[%0d]: got %b expected %b", i, obs(), O_GRANT);
            end
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (obs() !== O_ABORT || grant_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL wd abort: got %b cnt %h expected %b cnt %h", obs(), grant_cnt, O_ABORT, exp_cnt);
        end
        tick();
        n_total++;
        if (obs() !== O_BACK) begin
            n_bad++;
            $display("FAIL wd abort_single: got %b expected %b", obs(), O_BACK);
        end
        finish_release("wd", 1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (obs() !== O_IDLE) begin
                n_bad++;
                $display("FAIL wd no_regrant[%0d]: got %b expected %b", i, obs(), O_IDLE);
            end
        end
        dma_req = 1'b0;
        tick();
        run_txn("wd_after", 1, 3, 1, 1'b0);
    endtask
`else
    task automatic test_long_hold();
        run_txn("long_hold", 2, 100, 2, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_grant();
        dma_req = 1'b1;
        busak_n = 1'b1;
        tick();
        busak_n = 1'b0;
        tick();
        n_total++;
        if (obs() !== O_GRANT) begin
            n_bad++;
            $display("FAIL rst_mid grant: got %b expected %b", obs(), O_GRANT);
        end
        tick();
        tick();
        reset   = 1'b1;
        exp_cnt = 16'd0;
        tick();
        n_total++;
        if (obs() !== O_IDLE || grant_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL rst_mid edge: got %b cnt %h expected %b cnt %h", obs(), grant_cnt, O_IDLE, exp_cnt);
        end
        dma_req = 1'b0;
        busak_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_total++;
        if (obs() !== O_IDLE) begin
            n_bad++;
            $display("FAIL rst_mid exit: got %b expected %b", obs(), O_IDLE);
        end
    endtask

    task automatic test_wrap();
        force dut.r_grant_cnt = 16'hFFFF;
        #1;
        release dut.r_grant_cnt;
        #1;
        exp_cnt = 16'hFFFF;
        n_total++;
        if (grant_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL wrap_preload: got %h expected %h", grant_cnt, exp_cnt);
        end
        run_txn("wrap", 1, 2, 1, 1'b0);
        n_total++;
        if (grant_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_zero: got %h expected 0000", grant_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_spurious_ack();
        test_basic();
        test_gap();
        test_withdraw();
        test_random();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_long_hold();
`endif
        test_reset_mid_grant();
        test_wrap();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
